// File: rtl/etroc1_trigger_event_packer.sv
`default_nettype none
// ============================================================================
// Module  : etroc1_trigger_event_packer
// Brief   : Frames trigger windows of cache data as header/data/trailer events
//           in a FWFT FIFO drained over valid/ready. Optional build macro:
//           PACKER_ZERO_SUPPRESS_EN (never store zero-valued data words).
// Revision: 1.0 - initial release
// ============================================================================
module etroc1_trigger_event_packer #(
  parameter int FIFO_DEPTH = 32,
  parameter int FIFO_AW    = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trig,
  input  logic [4:0]  window_len,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [15:0] event_count,
  output logic [15:0] missed_count,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    TRAILER = 2'd2
  } state_t;

  localparam logic [FIFO_AW:0]   c_depth   = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   c_two     = (FIFO_AW+1)'(2);
  localparam logic [FIFO_AW-1:0] c_ptr_one = (FIFO_AW)'(1);

  state_t             state_q, state_d;
  logic               trig_q;
  logic [4:0]         cnt_q, cnt_d;
  logic [4:0]         dropped_q, dropped_d;
  logic [4:0]         nwords_q, nwords_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        evt_q, evt_d;
  logic [15:0]        miss_q, miss_d;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   occ_q;
  logic [31:0]        mem_q [FIFO_DEPTH];

  logic               trig_edge, room, keep, push, pop, miss_inc;
  logic [31:0]        push_data;
  logic [4:0]         wlen_clamped;
  logic [FIFO_AW:0]   free_words;

  assign trig_edge    = trig & ~trig_q;
  // Space is judged on registered occupancy only, so a same-cycle pop never helps.
  assign free_words   = c_depth - occ_q;
  assign room         = (free_words >= c_two);
  assign wlen_clamped = (window_len > 5'd16) ? 5'd16 : window_len;

`ifdef PACKER_ZERO_SUPPRESS_EN
  assign keep = (din != 32'd0);
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dropped_d = dropped_q;
    nwords_d  = nwords_q;
    ovf_d     = ovf_q;
    evt_d     = evt_q;
    miss_d    = miss_q;
    miss_inc  = 1'b0;
    push      = 1'b0;
    push_data = 32'd0;
    case (state_q)
      IDLE: begin
        if (trig_edge) begin
          if (room) begin
            push      = 1'b1;
            evt_d     = evt_q + 16'd1;
            push_data = {4'hA, 7'd0, wlen_clamped, evt_d};
            cnt_d     = wlen_clamped;
            state_d   = (wlen_clamped == 5'd0) ? TRAILER : COLLECT;
          end else begin
            miss_inc = 1'b1;
          end
        end
      end
      COLLECT: begin
        // Storing needs two free slots so the trailer always has a home.
        if (keep) begin
          if (room) begin
            push      = 1'b1;
            push_data = din;
            nwords_d  = nwords_q + 5'd1;
          end else begin
            ovf_d     = 1'b1;
            dropped_d = dropped_q + 5'd1;
          end
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = TRAILER;
      end
      TRAILER: begin
        push      = 1'b1;
        push_data = {4'hB, ovf_q, 14'd0, dropped_q, 3'd0, nwords_q};
        ovf_d     = 1'b0;
        dropped_d = 5'd0;
        nwords_d  = 5'd0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (trig_edge && (state_q != IDLE)) miss_inc = 1'b1;
    if (miss_inc && (miss_q != 16'hFFFF)) miss_d = miss_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      trig_q    <= 1'b0;
      cnt_q     <= 5'd0;
      dropped_q <= 5'd0;
      nwords_q  <= 5'd0;
      ovf_q     <= 1'b0;
      evt_q     <= 16'd0;
      miss_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      trig_q    <= trig;
      cnt_q     <= cnt_d;
      dropped_q <= dropped_d;
      nwords_q  <= nwords_d;
      ovf_q     <= ovf_d;
      evt_q     <= evt_d;
      miss_q    <= miss_d;
    end
  end

  assign dout_valid = (occ_q != '0);
  assign pop        = dout_valid & dout_ready;
  assign dout       = dout_valid ? mem_q[rd_ptr_q] : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + c_ptr_one;
      if (pop)  rd_ptr_q <= rd_ptr_q + c_ptr_one;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign event_count  = evt_q;
  assign missed_count = miss_q;
  assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_etroc1_trigger_event_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_etroc1_trigger_event_packer
// Brief   : Scoreboard bench for the trigger event packer (4-word FIFO build).
// Revision: 1.0 - initial release
// ============================================================================
module tb_etroc1_trigger_event_packer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trig = 1'b0;
  logic [4:0]  window_len = 5'd0;
  logic [31:0] din = 32'd0;
  logic        dout_ready = 1'b0;
  logic [31:0] dout;
  logic        dout_valid;
  logic [15:0] event_count;
  logic [15:0] missed_count;
  logic        busy;

  etroc1_trigger_event_packer #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .trig         (trig),
    .window_len   (window_len),
    .din          (din),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .event_count  (event_count),
    .missed_count (missed_count),
    .busy         (busy)
  );

  always #12 clk = ~clk;

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] exp_q [$];
  logic [31:0] din_tab [20];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [4:0] wl, input logic [15:0] ev);
    return {4'hA, 7'd0, wl, ev};
  endfunction

  function automatic logic [31:0] trl(input logic ovf, input logic [4:0] drp, input logic [4:0] nw);
    return {4'hB, ovf, 14'd0, drp, 3'd0, nw};
  endfunction

  function automatic bit kept(input logic [31:0] w);
`ifdef PACKER_ZERO_SUPPRESS_EN
    return (w != 32'd0);
`else
    return 1'b1;
`endif
  endfunction

  // Expected event when the consumer keeps the FIFO drained.
  task automatic push_expected(input int wl_eff, input logic [4:0] wl_hdr, input logic [15:0] ev);
    logic [4:0] n;
    n = 5'd0;
    exp_q.push_back(hdr(wl_hdr, ev));
    for (int i = 0; i < wl_eff; i++) begin
      if (kept(din_tab[i])) begin
        exp_q.push_back(din_tab[i]);
        n = n + 5'd1;
      end
    end
    exp_q.push_back(trl(1'b0, 5'd0, n));
  endtask

  always @(negedge clk) begin
    if (reset_n && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      else                   chk("dout", dout, exp_q.pop_front());
    end
  end

  task automatic run_event(input logic [4:0] wl, input int n_drive, input bit second_edge,
                           input bit chk_lat);
    @(posedge clk); #1;
    window_len = wl;
    trig       = 1'b1;
    for (int i = 0; i < n_drive; i++) begin
      @(posedge clk); #1;
      if (chk_lat && i == 0) begin
        chk("hdr_latency_valid", 32'(dout_valid), 32'd1);
        chk("hdr_latency", dout, hdr(wl, event_count));
      end
      if (chk_lat && i == 1) chk("data_latency", dout, din_tab[0]);
      din = din_tab[i];
      if (second_edge) trig = (i == 1);
    end
    @(posedge clk); #1;
    din  = 32'd0;
    trig = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !dout_valid && !busy) break;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_events", 32'(event_count), 32'd0);
    chk("rst_missed", 32'(missed_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n    = 1'b1;
    dout_ready = 1'b1;

    // Basic 3-word event
    din_tab[0] = 32'h11; din_tab[1] = 32'h22; din_tab[2] = 32'h33;
    push_expected(3, 5'd3, 16'd1);
    run_event(5'd3, 3, 1'b0, 1'b1);
    wait_drain("ev1");
    chk("ev1_count", 32'(event_count), 32'd1);

    // Zero in the middle of the window
    din_tab[1] = 32'h0;
    push_expected(3, 5'd3, 16'd2);
    run_event(5'd3, 3, 1'b0, 1'b0);
    wait_drain("ev2");
    chk("ev2_count", 32'(event_count), 32'd2);

    // Overflow with stalled consumer: 2 stored, 3 dropped
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) din_tab[i] = 32'h100 + 32'(i);
    exp_q.push_back(hdr(5'd5, 16'd3));
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h101);
    exp_q.push_back(trl(1'b1, 5'd3, 5'd2));
    run_event(5'd5, 5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("ovf_hold_valid", 32'(dout_valid), 32'd1);
    chk("ovf_hold_dout", dout, 32'hA005_0003);
    chk("ovf_busy", 32'(busy), 32'd0);

    // Edge while the FIFO is full
    run_event(5'd2, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("full_missed", 32'(missed_count), 32'd1);
    chk("full_events", 32'(event_count), 32'd3);
    chk("full_busy", 32'(busy), 32'd0);
    dout_ready = 1'b1;
    wait_drain("ovf");

    // Second edge inside the window
    for (int i = 0; i < 4; i++) din_tab[i] = 32'hC0DE_0000 + 32'(i);
    push_expected(4, 5'd4, 16'd4);
    run_event(5'd4, 4, 1'b1, 1'b0);
    wait_drain("ev4");
    chk("ev4_missed", 32'(missed_count), 32'd2);
    chk("ev4_count", 32'(event_count), 32'd4);

    // window_len above 16 is clamped
    for (int i = 0; i < 20; i++) din_tab[i] = 32'h5A00 + 32'(i);
    push_expected(16, 5'd16, 16'd5);
    run_event(5'd20, 20, 1'b0, 1'b0);
    wait_drain("clamp");

    // Zero-length window: header then trailer
    exp_q.push_back(hdr(5'd0, 16'd6));
    exp_q.push_back(trl(1'b0, 5'd0, 5'd0));
    run_event(5'd0, 0, 1'b0, 1'b0);
    wait_drain("wl0");
    chk("wl0_count", 32'(event_count), 32'd6);

    // Reset in the middle of an event
    for (int i = 0; i < 8; i++) din_tab[i] = 32'h7700 + 32'(i);
    push_expected(8, 5'd8, 16'd7);
    @(posedge clk); #1;
    window_len = 5'd8;
    trig       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      din = din_tab[i];
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 32'd0);
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_events", 32'(event_count), 32'd0);
    chk("mid_rst_missed", 32'(missed_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    trig = 1'b0;
    din  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    din_tab[0] = 32'h0000_0005;
    push_expected(1, 5'd1, 16'd1);
    run_event(5'd1, 1, 1'b0, 1'b0);
    wait_drain("post_rst");
    chk("post_rst_count", 32'(event_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
